// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared types and funct3 encodings for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        MISALIGNED = 2'd1,
        ACCESS     = 2'd2,
        ILLEGAL    = 2'd3
    } lsu_fault_t;

    localparam logic [2:0] LSU_B  = 3'd0;
    localparam logic [2:0] LSU_H  = 3'd1;
    localparam logic [2:0] LSU_W  = 3'd2;
    localparam logic [2:0] LSU_D  = 3'd3;
    localparam logic [2:0] LSU_BU = 3'd4;
    localparam logic [2:0] LSU_HU = 3'd5;
    localparam logic [2:0] LSU_WU = 3'd6;

endpackage

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ============================================================================
// Module      : load_store_unit_align
// Description : Combinational lane logic: legality, alignment, strobes,
//               store replication and load extraction/extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                        is_store_i,
    input  logic [2:0]                  funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]   offset_i,
    input  logic [XLEN-1:0]             store_data_i,
    input  logic [XLEN-1:0]             rdata_i,
    output logic                        legal_o,
    output logic                        misaligned_o,
    output logic [XLEN/8-1:0]           wstrb_o,
    output logic [XLEN-1:0]             wdata_o,
    output logic [XLEN-1:0]             load_data_o
);

    localparam int NB = XLEN / 8;

    logic [1:0]      size;
    logic [2:0]      off3;
    logic [2:0]      amask;
    logic [NB-1:0]   smask;
    logic [XLEN-1:0] shifted;

    assign size    = funct3_i[1:0];
    assign off3    = 3'(offset_i);
    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        legal_o = 1'b0;
        case (funct3_i)
            LSU_B, LSU_H, LSU_W: legal_o = 1'b1;
            LSU_D:               legal_o = (XLEN == 64);
            LSU_BU, LSU_HU:      legal_o = !is_store_i;
            LSU_WU:              legal_o = !is_store_i && (XLEN == 64);
            default:             legal_o = 1'b0;
        endcase
    end

    always_comb begin
        amask   = 3'b111;
        smask   = '1;
        wdata_o = store_data_i;
        case (size)
            2'd0: begin
                amask   = 3'b000;
                smask   = NB'(1);
                wdata_o = {NB{store_data_i[7:0]}};
            end
            2'd1: begin
                amask   = 3'b001;
                smask   = NB'(3);
                wdata_o = {(XLEN/16){store_data_i[15:0]}};
            end
            2'd2: begin
                amask   = 3'b011;
                smask   = NB'(15);
                wdata_o = {(XLEN/32){store_data_i[31:0]}};
            end
            default: begin
                amask   = 3'b111;
                smask   = '1;
                wdata_o = store_data_i;
            end
        endcase
    end

    assign misaligned_o = |(off3 & amask);
    assign wstrb_o      = smask << offset_i;

    // Signed casts sign-extend to XLEN; unsigned casts zero-extend.
    always_comb begin
        load_data_o = shifted;
        case (funct3_i)
            LSU_B:   load_data_o = XLEN'($signed(shifted[7:0]));
            LSU_H:   load_data_o = XLEN'($signed(shifted[15:0]));
            LSU_W:   load_data_o = XLEN'($signed(shifted[31:0]));
            LSU_BU:  load_data_o = XLEN'(shifted[7:0]);
            LSU_HU:  load_data_o = XLEN'(shifted[15:0]);
            LSU_WU:  load_data_o = XLEN'(shifted[31:0]);
            default: load_data_o = shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Handshaked single-access load/store unit with fault reporting
//               and bus timeout for the multicycle core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     addr,
    input  logic [XLEN-1:0]     store_data,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [1:0]          fault_cause,
    output logic [XLEN-1:0]     load_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t        state_q, state_d;
    lsu_fault_t        cause_q, cause_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OFFW-1:0]   offset_q, offset_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              in_idle;
    logic              timeout_hit;
    logic              al_store;
    logic [2:0]        al_funct3;
    logic [OFFW-1:0]   al_offset;
    logic              al_legal;
    logic              al_misaligned;
    logic [NB-1:0]     al_wstrb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_load;

    // One lane unit: live request fields while idle, latched fields afterwards.
    assign in_idle   = (state_q == IDLE);
    assign al_store  = in_idle ? is_store : we_q;
    assign al_funct3 = in_idle ? funct3 : funct3_q;
    assign al_offset = in_idle ? addr[OFFW-1:0] : offset_q;

    load_store_unit_align #(
        .XLEN (XLEN)
    ) u_align (
        .is_store_i   (al_store),
        .funct3_i     (al_funct3),
        .offset_i     (al_offset),
        .store_data_i (store_data),
        .rdata_i      (mem_rdata),
        .legal_o      (al_legal),
        .misaligned_o (al_misaligned),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cause_q     <= NONE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            offset_q    <= '0;
            load_data_q <= '0;
            mem_addr_q  <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            load_data_q <= load_data_d;
            mem_addr_q  <= mem_addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        load_data_d = load_data_q;
        mem_addr_d  = mem_addr_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    we_d     = is_store;
                    funct3_d = funct3;
                    offset_d = addr[OFFW-1:0];
                    if (!al_legal) begin
                        state_d = RESP;
                        cause_d = ILLEGAL;
                    end else if (al_misaligned) begin
                        state_d = RESP;
                        cause_d = MISALIGNED;
                    end else begin
                        state_d    = REQ;
                        cause_d    = NONE;
                        cnt_d      = '0;
                        mem_addr_d = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        wstrb_d    = al_wstrb;
                        wdata_d    = al_wdata;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_req_ready && mem_rvalid) begin
                    state_d = RESP;
                    if (!we_q) load_data_d = al_load;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    cause_d = ACCESS;
                end else if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid) begin
                    state_d = RESP;
                    if (!we_q) load_data_d = al_load;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    cause_d = ACCESS;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy          = !in_idle;
    assign done          = (state_q == RESP);
    assign fault         = done && (cause_q != NONE);
    assign fault_cause   = cause_q;
    assign load_data     = load_data_q;
    assign mem_req_valid = (state_q == REQ);
    assign mem_we        = mem_req_valid && we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wstrb     = wstrb_q;
    assign mem_wdata     = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit (RV32, RV64 and a
//               short-timeout RV32 instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start64;
    logic        is_store;
    logic [2:0]  funct3;
    logic [63:0] addr, store_data, mem_rdata;
    logic        mem_req_ready, mem_rvalid;

    logic        d32_busy, d32_done, d32_fault, d32_valid, d32_we;
    logic [1:0]  d32_cause;
    logic [31:0] d32_ld, d32_maddr, d32_wdata;
    logic [3:0]  d32_wstrb;

    logic        t4_busy, t4_done, t4_fault, t4_valid, t4_we;
    logic [1:0]  t4_cause;
    logic [31:0] t4_ld, t4_maddr, t4_wdata;
    logic [3:0]  t4_wstrb;

    logic        d64_busy, d64_done, d64_fault, d64_valid, d64_we;
    logic [1:0]  d64_cause;
    logic [63:0] d64_ld, d64_maddr, d64_wdata;
    logic [7:0]  d64_wstrb;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .is_store(is_store),
        .funct3(funct3), .addr(addr[31:0]), .store_data(store_data[31:0]),
        .busy(d32_busy), .done(d32_done), .fault(d32_fault), .fault_cause(d32_cause),
        .load_data(d32_ld), .mem_req_valid(d32_valid), .mem_req_ready(mem_req_ready),
        .mem_we(d32_we), .mem_addr(d32_maddr), .mem_wstrb(d32_wstrb),
        .mem_wdata(d32_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
    );

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut_to4 (
        .clk(clk), .reset(reset), .start(start32), .is_store(is_store),
        .funct3(funct3), .addr(addr[31:0]), .store_data(store_data[31:0]),
        .busy(t4_busy), .done(t4_done), .fault(t4_fault), .fault_cause(t4_cause),
        .load_data(t4_ld), .mem_req_valid(t4_valid), .mem_req_ready(mem_req_ready),
        .mem_we(t4_we), .mem_addr(t4_maddr), .mem_wstrb(t4_wstrb),
        .mem_wdata(t4_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
    );

    load_store_unit #(.XLEN(64), .TIMEOUT_CYCLES(16)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(d64_busy), .done(d64_done), .fault(d64_fault), .fault_cause(d64_cause),
        .load_data(d64_ld), .mem_req_valid(d64_valid), .mem_req_ready(mem_req_ready),
        .mem_we(d64_we), .mem_addr(d64_maddr), .mem_wstrb(d64_wstrb),
        .mem_wdata(d64_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Output view of whichever wide/narrow instance the current vector targets.
    logic        sel64;
    logic        s_busy, s_done, s_fault, s_valid, s_we;
    logic [1:0]  s_cause;
    logic [63:0] s_ld, s_maddr, s_wdata;
    logic [7:0]  s_wstrb;

    assign s_busy  = sel64 ? d64_busy  : d32_busy;
    assign s_done  = sel64 ? d64_done  : d32_done;
    assign s_fault = sel64 ? d64_fault : d32_fault;
    assign s_valid = sel64 ? d64_valid : d32_valid;
    assign s_we    = sel64 ? d64_we    : d32_we;
    assign s_cause = sel64 ? d64_cause : d32_cause;
    assign s_ld    = sel64 ? d64_ld    : {32'b0, d32_ld};
    assign s_maddr = sel64 ? d64_maddr : {32'b0, d32_maddr};
    assign s_wdata = sel64 ? d64_wdata : {32'b0, d32_wdata};
    assign s_wstrb = sel64 ? d64_wstrb : {4'b0, d32_wstrb};

    typedef struct {
        bit          w64;
        bit          st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sd;
        logic [63:0] rd;
        logic [1:0]  cause;
        logic [63:0] ld;
        logic [63:0] maddr;
        logic [7:0]  ws;
        logic [63:0] wd;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] model_ld [2];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input bit w64, input bit st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rd,
                        input logic [1:0] cause, input logic [63:0] ld,
                        input logic [63:0] maddr, input logic [7:0] ws, input logic [63:0] wd);
        vec_t v;
        v.w64 = w64; v.st = st; v.f3 = f3; v.addr = a; v.sd = sd; v.rd = rd;
        v.cause = cause; v.ld = ld; v.maddr = maddr; v.ws = ws; v.wd = wd;
        vecs.push_back(v);
    endtask

    // Zero-wait bus: ready and rvalid held high for the whole access.
    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        bit          req_seen, we_seen;
        logic [63:0] ma, wd, exp_ld;
        logic [7:0]  ws;
        logic [1:0]  cause;
        logic        flt;
        int          m;
        m = v.w64 ? 1 : 0;
        sel64 = v.w64;
        is_store = v.st; funct3 = v.f3; addr = v.addr;
        store_data = v.sd; mem_rdata = v.rd;
        mem_req_ready = 1'b1; mem_rvalid = 1'b1;
        start32 = !v.w64; start64 = v.w64;
        tick();
        start32 = 1'b0; start64 = 1'b0;
        lat = 0; req_seen = 0; we_seen = 0; ma = '0; wd = '0; ws = '0; cause = '0; flt = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (s_valid) begin
                req_seen = 1; we_seen = s_we; ma = s_maddr; ws = s_wstrb; wd = s_wdata;
            end
            if (s_done) begin
                lat = c; cause = s_cause; flt = s_fault;
                break;
            end
            tick();
        end
        exp_ld = (v.cause == 2'd0 && !v.st) ? v.ld : model_ld[m];
        model_ld[m] = exp_ld;
        check($sformatf("v%0d latency", idx), 64'(lat), (v.cause == 2'd0) ? 64'd2 : 64'd1);
        check($sformatf("v%0d cause", idx), 64'(cause), 64'(v.cause));
        check($sformatf("v%0d fault", idx), 64'(flt), 64'(v.cause != 2'd0));
        check($sformatf("v%0d bus_req", idx), 64'(req_seen), 64'(v.cause == 2'd0));
        check($sformatf("v%0d load_data", idx), s_ld, exp_ld);
        if (v.cause == 2'd0) begin
            check($sformatf("v%0d mem_addr", idx), ma, v.maddr);
            check($sformatf("v%0d mem_we", idx), 64'(we_seen), 64'(v.st));
            if (v.st) begin
                check($sformatf("v%0d wstrb", idx), 64'(ws), 64'(v.ws));
                check($sformatf("v%0d wdata", idx), wd, v.wd);
            end
        end
        tick();
        check($sformatf("v%0d done_pulse_busy", idx), {62'b0, s_done, s_busy}, 64'd0);
        mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dones;
        bit  stable_ok;
        int  n;

        reset = 1'b1; start32 = 1'b0; start64 = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = '0; store_data = '0; mem_rdata = '0; mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        sel64 = 1'b0;
        model_ld[0] = '0; model_ld[1] = '0;
        repeat (3) tick();

        check("rst ctrl32", {58'b0, d32_busy, d32_done, d32_fault, d32_valid, d32_we, d32_cause[0]} | 64'(d32_cause), 64'd0);
        check("rst load_data32", 64'(d32_ld), 64'd0);
        check("rst mem_addr32", 64'(d32_maddr), 64'd0);
        check("rst wstrb_wdata32", {28'b0, d32_wstrb, d32_wdata}, 64'd0);
        check("rst ctrl64", {59'b0, d64_busy, d64_done, d64_valid, d64_cause}, 64'd0);
        check("rst load_data64", d64_ld, 64'd0);
        reset = 1'b0;
        tick();

        //   w64 st f3    addr           sd                     rd                     cause ld                     maddr        ws     wd
        addv(0, 0, 3'd0, 64'h103,       64'h0,                 64'h80FF_1234,         2'd0, 64'hFFFF_FF80,         64'h100,     8'h0,  64'h0);
        addv(0, 0, 3'd4, 64'h103,       64'h0,                 64'h80FF_1234,         2'd0, 64'h80,                64'h100,     8'h0,  64'h0);
        addv(0, 0, 3'd1, 64'h102,       64'h0,                 64'h80FF_1234,         2'd0, 64'hFFFF_80FF,         64'h100,     8'h0,  64'h0);
        addv(0, 0, 3'd5, 64'h100,       64'h0,                 64'h80FF_1234,         2'd0, 64'h1234,              64'h100,     8'h0,  64'h0);
        addv(0, 0, 3'd2, 64'h10,        64'h0,                 64'hCAFE_F00D,         2'd0, 64'hCAFE_F00D,         64'h10,      8'h0,  64'h0);
        addv(0, 0, 3'd2, 64'h6,         64'h0,                 64'h1111_1111,         2'd1, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(0, 0, 3'd1, 64'h101,       64'h0,                 64'h1111_1111,         2'd1, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(0, 1, 3'd0, 64'h301,       64'h1234_56AB,         64'h0,                 2'd0, 64'h0,                 64'h300,     8'h2,  64'hABAB_ABAB);
        addv(0, 1, 3'd1, 64'h202,       64'h0000_BEEF,         64'h0,                 2'd0, 64'h0,                 64'h200,     8'hC,  64'hBEEF_BEEF);
        addv(0, 1, 3'd2, 64'h404,       64'h89AB_CDEF,         64'h0,                 2'd0, 64'h0,                 64'h404,     8'hF,  64'h89AB_CDEF);
        addv(0, 0, 3'd3, 64'h8,         64'h0,                 64'h0,                 2'd3, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(0, 1, 3'd4, 64'h0,         64'h0,                 64'h0,                 2'd3, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(0, 0, 3'd7, 64'h0,         64'h0,                 64'h0,                 2'd3, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(0, 0, 3'd3, 64'h1,         64'h0,                 64'h0,                 2'd3, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(0, 0, 3'd0, 64'h1,         64'h0,                 64'h0000_7F00,         2'd0, 64'h7F,                64'h0,       8'h0,  64'h0);
        addv(0, 1, 3'd2, 64'h2,         64'h5555_5555,         64'h0,                 2'd1, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(0, 0, 3'd6, 64'h4,         64'h0,                 64'h0,                 2'd3, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(1, 0, 3'd6, 64'h4,         64'h0,                 64'hDEAD_BEEF_0000_0000, 2'd0, 64'h0000_0000_DEAD_BEEF, 64'h0,   8'h0,  64'h0);
        addv(1, 0, 3'd2, 64'h4,         64'h0,                 64'hDEAD_BEEF_0000_0000, 2'd0, 64'hFFFF_FFFF_DEAD_BEEF, 64'h0,   8'h0,  64'h0);
        addv(1, 0, 3'd3, 64'h8,         64'h0,                 64'h0123_4567_89AB_CDEF, 2'd0, 64'h0123_4567_89AB_CDEF, 64'h8,   8'h0,  64'h0);
        addv(1, 0, 3'd3, 64'hC,         64'h0,                 64'h0,                 2'd1, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(1, 1, 3'd3, 64'h10,        64'h0123_4567_89AB_CDEF, 64'h0,               2'd0, 64'h0,                 64'h10,      8'hFF, 64'h0123_4567_89AB_CDEF);
        addv(1, 1, 3'd2, 64'h14,        64'hFFFF_FFFF_1122_3344, 64'h0,               2'd0, 64'h0,                 64'h10,      8'hF0, 64'h1122_3344_1122_3344);
        addv(1, 1, 3'd1, 64'h16,        64'h5566,              64'h0,                 2'd0, 64'h0,                 64'h10,      8'hC0, 64'h5566_5566_5566_5566);
        addv(1, 1, 3'd6, 64'h0,         64'h0,                 64'h0,                 2'd3, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(1, 0, 3'd5, 64'h7,         64'h0,                 64'h0,                 2'd1, 64'h0,                 64'h0,       8'h0,  64'h0);
        addv(1, 0, 3'd4, 64'h7,         64'h0,                 64'h9A00_0000_0000_0000, 2'd0, 64'h9A,              64'h0,       8'h0,  64'h0);
        addv(1, 0, 3'd0, 64'h7,         64'h0,                 64'h9A00_0000_0000_0000, 2'd0, 64'hFFFF_FFFF_FFFF_FF9A, 64'h0,   8'h0,  64'h0);
        addv(1, 1, 3'd0, 64'h5,         64'h77,                64'h0,                 2'd0, 64'h0,                 64'h0,       8'h20, 64'h7777_7777_7777_7777);

        foreach (vecs[i]) run_vec(vecs[i], i);
        sel64 = 1'b0;
        repeat (2) tick();

        // SH with a three-cycle ready stall, then ready and rvalid together.
        is_store = 1'b1; funct3 = 3'd1; addr = 64'h202; store_data = 64'hBEEF;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        stable_ok = 1; dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (!(d32_valid && d32_we && d32_maddr == 32'h200 && d32_wstrb == 4'b1100 &&
                  d32_wdata == 32'hBEEF_BEEF)) stable_ok = 0;
            if (d32_done) dones++;
            if (i < 3) tick();
        end
        mem_req_ready = 1'b1; mem_rvalid = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        check("sh_stall done_nofault", {62'b0, d32_done, d32_fault}, 64'd2);
        for (int i = 0; i < 4; i++) begin
            if (d32_done) dones++;
            tick();
        end
        check("sh_stall request_stable", 64'(stable_ok), 64'd1);
        check("sh_stall done_count", 64'(dones), 64'd1);
        check("sh_stall idle_after", {62'b0, d32_busy, d32_valid}, 64'd0);

        // Start held high while busy and during RESP: exactly one access.
        is_store = 1'b0; funct3 = 3'd2; addr = 64'h50; mem_rdata = 64'h1111_2222;
        start32 = 1'b1;
        tick();
        addr = 64'h60; funct3 = 3'd0;
        dones = 0; stable_ok = 1;
        for (int i = 0; i < 2; i++) begin
            if (!(d32_valid && d32_maddr == 32'h50)) stable_ok = 0;
            tick();
        end
        mem_req_ready = 1'b1; mem_rvalid = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        if (d32_done) dones++;
        tick();
        start32 = 1'b0;
        check("busy_start idle_after_resp", 64'(d32_busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (d32_done) dones++;
            tick();
        end
        check("busy_start addr_stable", 64'(stable_ok), 64'd1);
        check("busy_start done_count", 64'(dones), 64'd1);
        check("busy_start load_data", 64'(d32_ld), 64'h1111_2222);

        // Reset while in WAIT, then a late rvalid.
        is_store = 1'b0; funct3 = 3'd2; addr = 64'h40; mem_rdata = 64'h1234_5678;
        mem_req_ready = 1'b1; mem_rvalid = 1'b0;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        check("rst_wait in_wait", {62'b0, d32_busy, d32_valid}, 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_rvalid = 1'b1;
        check("rst_wait idle", {62'b0, d32_busy, d32_valid}, 64'd0);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d32_done || d32_busy) dones++;
        end
        mem_rvalid = 1'b0;
        check("rst_wait no_done", 64'(dones), 64'd0);
        check("rst_wait load_data", 64'(d32_ld), 64'd0);

        // Timeout on the 4-cycle instance: LW with ready never asserted.
        is_store = 1'b0; funct3 = 3'd2; addr = 64'h20;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        check("timeout req_entry", 64'(t4_valid), 64'd1);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (t4_done) break;
            tick();
            n++;
        end
        check("timeout cycles_after_req", 64'(n), 64'd4);
        check("timeout cause_fault", {61'b0, t4_fault, t4_cause}, 64'b110);
        tick();
        check("timeout valid_low_after", {62'b0, t4_valid, t4_busy}, 64'd0);
        check("timeout long_inst_still_req", 64'(d32_valid), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
